rtc_alarm: RTL
==============

RTC_ALARM -- requirements
Module: rtc_alarm

Interface
REQ-001 The block SHALL provide parameter CLK_HZ, default 50000000, giving the input clock cycles per second (minimum 2).
REQ-002 The block SHALL provide parameter MODE_12H, default 0: 0 = 24-hour display, 1 = 12-hour display with pm flag.
REQ-003 The block SHALL provide parameter ALARM_LEN_S, default 10, giving the maximum ring duration in seconds (1..63).
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 set_en  input  1  one-cycle write strobe for the field chosen by set_sel.
REQ-007 set_sel  input  3  field select: 0 sec, 1 min, 2 hour, 3 alarm min, 4 alarm hour, 5-7 no field.
REQ-008 set_val  input  6  binary value to write.
REQ-009 alarm_en  input  1  alarm arm (level).
REQ-010 alarm_ack  input  1  stops an active ring (level, sampled each cycle).
REQ-011 sec_bcd, min_bcd, hour_bcd  output  8 each  two BCD digits, tens in [7:4], units in [3:0].
REQ-012 pm  output  1  high when internal hour >= 12; forced 0 when MODE_12H=0.
REQ-013 tick_1hz  output  1  one-cycle pulse once per second.
REQ-014 alarm_ring  output  1  high while alarm is ringing.

Function
REQ-015 Prescaler SHALL count 0..CLK_HZ-1 and wrap to 0; tick_1hz SHALL be high for exactly the cycle in which the count equals CLK_HZ-1; no derived clocks.
REQ-016 Internal time SHALL be binary, always 24-hour: sec 0..59, min 0..59, hour 0..23.
REQ-017 On tick: sec increments; at sec=59 it becomes 0 and min increments; at min=59 with sec=59 min becomes 0 and hour increments; 23:59:59 wraps to 00:00:00, all in the same cycle.
REQ-018 Time registers SHALL update on the clock edge that ends the tick cycle; BCD outputs SHALL be combinational decode of the registers (zero added latency).
REQ-019 MODE_12H=1: displayed hour SHALL be 12 for internal 0 and 12, hour-12 for 13..23, hour otherwise; pm = (hour >= 12).
REQ-020 set_en with set_val in range (sec/min/alarm min: 0..59; hour/alarm hour: 0..23) SHALL load the field at the next edge; an out-of-range value or set_sel 5..7 SHALL leave all fields unchanged.
REQ-021 A cycle with set_en=1 SHALL suppress time advance for that cycle (a coincident tick is dropped for all fields); the prescaler keeps counting, except that a valid sec write also clears the prescaler to 0.
REQ-022 Alarm FSM states: IDLE, RING.
REQ-023 IDLE->RING when alarm_en=1 and a tick (not suppressed) makes the time hour:min:00 with hour=alarm hour and min=alarm min; alarm_ring goes high the cycle after that edge.
REQ-024 RING->IDLE when alarm_ack=1, or alarm_en=0, or ALARM_LEN_S ticks have elapsed since entry; alarm_ring goes low the cycle after the leaving condition is sampled.
REQ-025 Writing time or alarm fields SHALL never trigger the alarm directly; only a tick-driven transition matches.
REQ-026 If alarm_ack is held high at the match tick, the FSM SHALL enter RING and leave it on the following cycle (one-cycle ring).

Reset
REQ-027 rst=1 at an edge SHALL force prescaler 0, time 00:00:00, alarm time 00:00, FSM IDLE, tick_1hz 0, alarm_ring 0, regardless of set_en or tick.
REQ-028 After reset, outputs SHALL read sec_bcd=0x00, min_bcd=0x00, hour_bcd=0x00 (0x12 with pm=0 when MODE_12H=1).
REQ-029 rst during RING SHALL drop alarm_ring the following cycle and discard the ring counter.

Verification
REQ-030 CLK_HZ=4, release reset, run 12 cycles -> tick_1hz pulses on cycles 4, 8, 12; sec_bcd 0x01, 0x02, 0x03.
REQ-031 Set hour=23, min=59, sec=59, one tick -> 00:00:00 in one cycle; MODE_12H=1 shows hour_bcd 0x12, pm 0; at 13:00 shows 0x01, pm 1.
REQ-032 set_en with set_sel=1, set_val=60 -> min unchanged; set_sel=6 -> nothing changes; valid write coincident with tick -> tick dropped.
REQ-033 Alarm 07:30, alarm_en=1, time 07:29:59, tick -> alarm_ring high next cycle; ALARM_LEN_S=3 -> low after 3 further ticks.
REQ-034 Ringing, alarm_ack pulse -> alarm_ring low next cycle; alarm_en=0 -> no ring at match; direct write to 07:30:00 -> no ring.
REQ-035 rst asserted while ringing and mid-prescale -> next cycle all outputs at reset values and the first tick occurs CLK_HZ cycles after rst release.

Source files
------------

// File: rtl/rtc_alarm.sv
// Real-time clock with prescaled 1 Hz tick, BCD display, 12/24 h mode and one-shot alarm.
// Time lives in binary 24 h registers; display decode is purely combinational.
module rtc_alarm #(
  parameter int CLK_HZ      = 50000000,
  parameter int MODE_12H    = 0,
  parameter int ALARM_LEN_S = 10
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       set_en,
  input  logic [2:0] set_sel,
  input  logic [5:0] set_val,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic       tick_1hz,
  output logic       alarm_ring
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [5:0] RING_LAST = 6'(ALARM_LEN_S - 1);

  typedef enum logic {IDLE, RING} state_t;

  logic [PW-1:0] presc;
  logic [5:0]    sec, min, al_min;
  logic [4:0]    hour, al_hour;
  logic [5:0]    sec_inc, min_inc;
  logic [4:0]    hour_inc, disp_hour;
  logic          tick, wr_ok, adv, sec_wrap, min_wrap, match;
  state_t        state, state_nxt;
  logic [5:0]    ring_cnt, ring_cnt_nxt;

  assign tick     = (presc == PMAX);
  assign tick_1hz = tick;

  always_comb begin
    wr_ok = 1'b0;
    case (set_sel)
      3'd0, 3'd1, 3'd3: wr_ok = (set_val <= 6'd59);
      3'd2, 3'd4:       wr_ok = (set_val <= 6'd23);
      default:          wr_ok = 1'b0;
    endcase
  end

  // Any write strobe, valid or not, freezes time for that cycle.
  assign adv      = tick && !set_en;
  assign sec_wrap = (sec == 6'd59);
  assign min_wrap = (min == 6'd59);

  always_comb begin
    sec_inc  = sec_wrap ? 6'd0 : sec + 6'd1;
    min_inc  = sec_wrap ? (min_wrap ? 6'd0 : min + 6'd1) : min;
    hour_inc = (sec_wrap && min_wrap) ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1) : hour;
  end

  assign match = alarm_en && adv && sec_wrap && (min_inc == al_min) && (hour_inc == al_hour);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      presc <= '0;
    end else if ((set_en && wr_ok && set_sel == 3'd0) || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      al_min  <= '0;
      al_hour <= '0;
    end else if (set_en) begin
      if (wr_ok) begin
        case (set_sel)
          3'd0:    sec     <= set_val;
          3'd1:    min     <= set_val;
          3'd2:    hour    <= set_val[4:0];
          3'd3:    al_min  <= set_val;
          3'd4:    al_hour <= set_val[4:0];
          default: ;
        endcase
      end
    end else if (adv) begin
      sec  <= sec_inc;
      min  <= min_inc;
      hour <= hour_inc;
    end
  end

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    case (state)
      IDLE: begin
        if (match) begin
          state_nxt    = RING;
          ring_cnt_nxt = '0;
        end
      end
      RING: begin
        if (alarm_ack || !alarm_en || (tick && ring_cnt == RING_LAST)) begin
          state_nxt = IDLE;
        end else if (tick) begin
          ring_cnt_nxt = ring_cnt + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state    <= IDLE;
      ring_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
    end
  end

  assign alarm_ring = (state == RING);

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    if (v >= 6'd50)      begin t = 4'd5; r = v - 6'd50; end
    else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
    else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
    else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
    else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
    else                 begin t = 4'd0; r = v;          end
    return {t, r[3:0]};
  endfunction

  always_comb begin
    disp_hour = hour;
    pm        = 1'b0;
    if (MODE_12H != 0) begin
      pm = (hour >= 5'd12);
      if (hour == 5'd0)      disp_hour = 5'd12;
      else if (hour > 5'd12) disp_hour = hour - 5'd12;
    end
  end

  assign sec_bcd  = to_bcd(sec);
  assign min_bcd  = to_bcd(min);
  assign hour_bcd = to_bcd({1'b0, disp_hour});

endmodule
